// File: rtl/filter_pkg.sv
// ============================================================================
//  Module      : filter_pkg
//  Description : Shared types and helpers for the filter coefficient store:
//                burst-engine state encoding and a constant clog2 function.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package filter_pkg;

  // Burst read engine states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Ceiling log2, usable in parameter expressions
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/filter_coeff_skid.sv
// ============================================================================
//  Module      : filter_coeff_skid
//  Description : Two-entry valid/ready output buffer. The upstream side has
//                no ready; the producer issues only when o_count shows room.
//                o_data is the registered head entry.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module filter_coeff_skid #(
  parameter int PAYLOAD_W = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  input  logic [PAYLOAD_W-1:0] i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [PAYLOAD_W-1:0] o_data,
  output logic [1:0]           o_count
);

  logic [PAYLOAD_W-1:0] r_main;
  logic                 r_main_vld;
  logic [PAYLOAD_W-1:0] r_skid;
  logic                 r_skid_vld;
  logic                 w_pop;

  assign w_pop = r_main_vld & i_ready;

  // Head register refills from the skid entry first, then from the input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main     <= '0;
      r_main_vld <= 1'b0;
      r_skid     <= '0;
      r_skid_vld <= 1'b0;
    end else begin
      if (!r_main_vld || w_pop) begin
        if (r_skid_vld) begin
          r_main     <= r_skid;
          r_main_vld <= 1'b1;
          r_skid_vld <= i_valid;
          if (i_valid) r_skid <= i_data;
        end else begin
          r_main_vld <= i_valid;
          if (i_valid) r_main <= i_data;
        end
      end else if (i_valid) begin
        r_skid     <= i_data;
        r_skid_vld <= 1'b1;
      end
    end
  end

  assign o_valid = r_main_vld;
  assign o_data  = r_main;
  assign o_count = {1'b0, r_main_vld} + {1'b0, r_skid_vld};

endmodule

`default_nettype wire

// File: rtl/filter_coeff_store.sv
// ============================================================================
//  Module      : filter_coeff_store
//  Description : Multi-channel coefficient store with host write port and a
//                burst read engine streaming taps over valid/ready.
//                Optional macro COEFF_PARITY_EN stores an even-parity bit per
//                word and flags mismatches on out_perr.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module filter_coeff_store
  import filter_pkg::*;
#(
  parameter int  DATA_W = 16,
  parameter int  DEPTH  = 512,
  parameter int  NUM_CH = 4,
  localparam int ADDR_W = clog2(DEPTH),
  localparam int CH_W   = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [ADDR_W:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_start,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_len,
  output logic              rd_busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_perr,
  output logic              wr_err,
  input  logic              err_clr
);

`ifdef COEFF_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int MEM_W = DATA_W + PAR_W;
  localparam int IDX_W = ADDR_W + CH_W;
  localparam int MEM_N = NUM_CH * DEPTH;
  localparam int PAY_W = DATA_W + 2;
  localparam logic [ADDR_W:0]   DEPTH_X   = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  // Flat storage, channel-major: index = ch*DEPTH + addr
  logic [MEM_W-1:0]  r_mem [MEM_N];

  state_t            r_state;
  logic [CH_W-1:0]   r_ch;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remain;
  logic              r_busy;
  logic              r_rd_vld;
  logic              r_rd_last;
  logic [MEM_W-1:0]  r_rd_word;
  logic              r_wr_err;

  logic              w_wr_ok;
  logic              w_wr_bad;
  logic              w_start_ok;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [MEM_W-1:0]  w_wr_word;
  logic              w_issue;
  logic              w_room;
  logic              w_pop;
  logic              w_perr;
  logic [2:0]        w_occ;
  logic              w_sk_valid;
  logic [PAY_W-1:0]  w_sk_data;
  logic [1:0]        w_sk_count;

  assign w_wr_ok    = wr_en && (wr_addr < DEPTH_X) && (32'(wr_ch) < 32'(NUM_CH));
  assign w_wr_bad   = wr_en && !w_wr_ok;
  assign w_start_ok = (rd_len != '0) && (rd_len <= DEPTH_X) && (32'(rd_ch) < 32'(NUM_CH));
  assign w_wr_idx   = IDX_W'(wr_ch) * IDX_W'(DEPTH) + IDX_W'(wr_addr[ADDR_W-1:0]);
  assign w_rd_idx   = IDX_W'(r_ch) * IDX_W'(DEPTH) + IDX_W'(r_addr);

`ifdef COEFF_PARITY_EN
  assign w_wr_word = {^wr_data, wr_data};
  assign w_perr    = ^r_rd_word;
`else
  assign w_wr_word = wr_data;
  assign w_perr    = 1'b0;
`endif

  // Entries committed to the buffer after this edge: held + in flight - leaving.
  // A new read may issue only if that leaves a free slot for its data.
  assign w_pop   = w_sk_valid & out_ready;
  assign w_occ   = {1'b0, w_sk_count} + {2'b00, r_rd_vld} - {2'b00, w_pop};
  assign w_room  = (w_occ < 3'd2);
  assign w_issue = (r_state == ST_STREAM) && w_room;

  // Host write port; reads in the same cycle see the previous contents
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[w_wr_idx] <= w_wr_word;
  end

  // Synchronous array read feeding the output buffer
  always_ff @(posedge clk) begin
    if (w_issue) r_rd_word <= r_mem[w_rd_idx];
  end

  // Read pipeline valid and last-tap tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld  <= 1'b0;
      r_rd_last <= 1'b0;
    end else begin
      r_rd_vld  <= w_issue;
      r_rd_last <= w_issue && (r_remain == LEN_ONE);
    end
  end

  // Sticky illegal-write flag; a new violation beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_err <= 1'b0;
    end else if (w_wr_bad) begin
      r_wr_err <= 1'b1;
    end else if (err_clr) begin
      r_wr_err <= 1'b0;
    end
  end

  // Burst engine: latch request, issue wrapped reads, wait for last handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ch     <= '0;
      r_addr   <= '0;
      r_remain <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (rd_start && w_start_ok) begin
            r_ch     <= rd_ch;
            r_addr   <= rd_base;
            r_remain <= rd_len;
            r_busy   <= 1'b1;
            r_state  <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_issue) begin
            r_addr   <= (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;
            r_remain <= r_remain - 1'b1;
            if (r_remain == LEN_ONE) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pop && w_sk_data[DATA_W]) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  filter_coeff_skid #(
    .PAYLOAD_W (PAY_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (r_rd_vld),
    .i_data  ({w_perr, r_rd_last, r_rd_word[DATA_W-1:0]}),
    .o_valid (w_sk_valid),
    .i_ready (out_ready),
    .o_data  (w_sk_data),
    .o_count (w_sk_count)
  );

  assign rd_busy   = r_busy;
  assign out_valid = w_sk_valid;
  assign out_data  = w_sk_data[DATA_W-1:0];
  assign out_last  = w_sk_data[DATA_W] & w_sk_valid;
  assign out_perr  = w_sk_data[DATA_W+1] & w_sk_valid;
  assign wr_err    = r_wr_err;

endmodule

`default_nettype wire
